// File: rtl/pio_in_pkg.sv
// Shared register offsets and capture-mode encodings for the parallel input port.
package pio_in_pkg;

    localparam logic [1:0] ADDR_DATA     = 2'd0;
    localparam logic [1:0] ADDR_IRQ_MASK = 2'd1;
    localparam logic [1:0] ADDR_RSVD     = 2'd2;
    localparam logic [1:0] ADDR_EDGE_CAP = 2'd3;

    localparam int EDGE_RISE = 0;
    localparam int EDGE_FALL = 1;
    localparam int EDGE_ANY  = 2;

endpackage

// File: rtl/pio_in_sync_debounce.sv
// One input bit: metastability synchroniser followed by a consecutive-sample debouncer.
// While load is high the filter tracks the synchronised input directly (warm-up).
module pio_in_sync_debounce #(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 1
) (
    input  logic clk,
    input  logic reset,
    input  logic load,
    input  logic in_bit,
    output logic stable
);

    localparam int               CNT_W  = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_TC = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   sync_out;
    logic [CNT_W-1:0]       cnt_q;

    // Synchroniser shift chain; the last stage is the first safe sample.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], in_bit};
        end
    end

    assign sync_out = sync_q[SYNC_STAGES-1];

    // Filter: flip only after DEBOUNCE_CYCLES consecutive differing samples;
    // any agreeing sample throws away a partial count.
    always_ff @(posedge clk) begin
        if (reset) begin
            stable <= 1'b0;
            cnt_q  <= '0;
        end else if (load) begin
            stable <= sync_out;
            cnt_q  <= '0;
        end else if (sync_out == stable) begin
            cnt_q <= '0;
        end else if (cnt_q == CNT_TC) begin
            stable <= ~stable;
            cnt_q  <= '0;
        end else begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

endmodule

// File: rtl/pio_in_edge_irq.sv
// Debounced parallel input port with per-bit edge capture (write-1-to-clear),
// maskable level interrupt and a read-latency-1 Avalon-MM slave interface.
module pio_in_edge_irq
    import pio_in_pkg::*;
#(
    parameter int WIDTH           = 8,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 1,
    parameter int EDGE_TYPE       = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write,
    input  logic [31:0]      writedata,
    input  logic [WIDTH-1:0] in_port,
    output logic [31:0]      readdata,
    output logic             irq
);

    // One extra cycle beyond the synchroniser depth so prev has caught up with
    // stable before edge detection is enabled.
    localparam int                WARM_W    = $clog2(SYNC_STAGES + 2);
    localparam logic [WARM_W-1:0] WARM_LOAD = WARM_W'(SYNC_STAGES + 1);

    logic [WARM_W-1:0] warm_cnt;
    logic              settled;
    logic              warm_load;
    logic [WIDTH-1:0]  stable;
    logic [WIDTH-1:0]  prev_q;
    logic [WIDTH-1:0]  edge_raw;
    logic [WIDTH-1:0]  edge_det;
    logic [WIDTH-1:0]  mask_q;
    logic [WIDTH-1:0]  mask_next;
    logic [WIDTH-1:0]  cap_q;
    logic [WIDTH-1:0]  cap_next;
    logic [WIDTH-1:0]  clr;
    logic              wr_en;
    logic [31:0]       rd_mux;
    logic              unused_wd;

    assign unused_wd = ^writedata;
    assign warm_load = ~settled;

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        pio_in_sync_debounce #(
            .SYNC_STAGES     (SYNC_STAGES),
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
        ) u_sync_debounce (
            .clk    (clk),
            .reset  (reset),
            .load   (warm_load),
            .in_bit (in_port[i]),
            .stable (stable[i])
        );
    end

    // Warm-up down-counter; settled latches once it hits terminal count.
    always_ff @(posedge clk) begin
        if (reset) begin
            warm_cnt <= WARM_LOAD;
            settled  <= 1'b0;
        end else if (warm_cnt != '0) begin
            warm_cnt <= warm_cnt - WARM_W'(1);
        end else begin
            settled <= 1'b1;
        end
    end

    // Edge selection by capture mode, suppressed until the filters have settled.
    always_comb begin
        if (EDGE_TYPE == EDGE_FALL) begin
            edge_raw = ~stable & prev_q;
        end else if (EDGE_TYPE == EDGE_ANY) begin
            edge_raw = stable ^ prev_q;
        end else begin
            edge_raw = stable & ~prev_q;
        end
        edge_det = settled ? edge_raw : '0;
    end

    assign wr_en     = chipselect & write;
    assign clr       = (wr_en && address == ADDR_EDGE_CAP) ? writedata[WIDTH-1:0] : '0;
    assign mask_next = (wr_en && address == ADDR_IRQ_MASK) ? writedata[WIDTH-1:0] : mask_q;
    assign cap_next  = (cap_q & ~clr) | edge_det;

    // Register read mux, zero-extended; reserved and unused bits read 0.
    always_comb begin
        rd_mux = '0;
        case (address)
            ADDR_DATA:     rd_mux[WIDTH-1:0] = stable;
            ADDR_IRQ_MASK: rd_mux[WIDTH-1:0] = mask_q;
            ADDR_EDGE_CAP: rd_mux[WIDTH-1:0] = cap_q;
            default:       rd_mux = '0;
        endcase
    end

    // Register state; irq looks at next-state values so set/clear act on the same edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            prev_q   <= '0;
            mask_q   <= '0;
            cap_q    <= '0;
            readdata <= '0;
            irq      <= 1'b0;
        end else begin
            prev_q   <= stable;
            mask_q   <= mask_next;
            cap_q    <= cap_next;
            readdata <= rd_mux;
            irq      <= |(cap_next & mask_next);
        end
    end

endmodule

// File: tb/tb_pio_in_edge_irq.sv
// Self-checking bench: three configurations of pio_in_edge_irq on a shared bus.
`timescale 1ns/1ps
module tb_pio_in_edge_irq;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  address;
    logic        chipselect;
    logic        write;
    logic [31:0] writedata;
    logic [7:0]  in_a;
    logic [7:0]  in_b;
    logic [31:0] in_c;
    logic [31:0] rd_a, rd_b, rd_c;
    logic        irq_a, irq_b, irq_c;

    always #5 clk = ~clk;

    pio_in_edge_irq dut_a (
        .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
        .write(write), .writedata(writedata), .in_port(in_a),
        .readdata(rd_a), .irq(irq_a)
    );

    pio_in_edge_irq #(.DEBOUNCE_CYCLES(4)) dut_b (
        .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
        .write(write), .writedata(writedata), .in_port(in_b),
        .readdata(rd_b), .irq(irq_b)
    );

    pio_in_edge_irq #(.WIDTH(32), .EDGE_TYPE(2)) dut_c (
        .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
        .write(write), .writedata(writedata), .in_port(in_c),
        .readdata(rd_c), .irq(irq_c)
    );

    typedef struct {
        int          due;
        int          dut;
        logic [31:0] rd;
        logic        irq;
        string       name;
    } exp_t;

    typedef struct {
        logic        rst;
        logic [7:0]  din;
        logic [1:0]  a;
        logic        w;
        logic [31:0] wd;
        logic [31:0] erd;
        logic        eirq;
    } vec_t;

    exp_t sb[$];
    vec_t vt[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc_n  = 0;

    always @(posedge clk) cyc_n <= cyc_n + 1;

    // Scoreboard: pop every expectation due this cycle and compare mid-cycle.
    always @(negedge clk) begin
        exp_t        e;
        logic [31:0] ard;
        logic        airq;
        while (sb.size() > 0 && sb[0].due <= cyc_n) begin
            e = sb.pop_front();
            case (e.dut)
                0:       begin ard = rd_a; airq = irq_a; end
                1:       begin ard = rd_b; airq = irq_b; end
                default: begin ard = rd_c; airq = irq_c; end
            endcase
            checks++;
            if (e.due != cyc_n || ard !== e.rd || airq !== e.irq) begin
                errors++;
                $display("FAIL %s: readdata=%h irq=%b, expected readdata=%h irq=%b (cycle %0d due %0d)",
                         e.name, ard, airq, e.rd, e.irq, cyc_n, e.due);
            end
        end
    end

    task automatic expect_at(input int dut, input logic [31:0] rd, input logic irq_e, input string nm);
        exp_t e;
        e.due  = cyc_n + 1;
        e.dut  = dut;
        e.rd   = rd;
        e.irq  = irq_e;
        e.name = nm;
        sb.push_back(e);
    endtask

    task automatic bus(input logic [1:0] a, input logic w, input logic [31:0] wd);
        address    = a;
        chipselect = 1'b1;
        write      = w;
        writedata  = wd;
        @(posedge clk);
        #1;
    endtask

    function automatic void add(input logic rst, input logic [7:0] din, input logic [1:0] a,
                                input logic w, input logic [31:0] wd,
                                input logic [31:0] erd, input logic eirq);
        vec_t v;
        v.rst = rst; v.din = din; v.a = a; v.w = w; v.wd = wd; v.erd = erd; v.eirq = eirq;
        vt.push_back(v);
    endfunction

    initial begin
        logic [31:0] warm_exp [4];
        int          j;

        reset      = 1'b1;
        in_a       = 8'hFF;
        in_b       = 8'h00;
        in_c       = 32'h0;
        address    = 2'd0;
        chipselect = 1'b0;
        write      = 1'b0;
        writedata  = 32'h0;

        // dut_a main table: reset with inputs high, warm-up, rising capture,
        // mask/irq, W1C, set-wins-over-clear, reserved and read-only writes.
        //   rst  din    a  w  wd            erd           irq
        add(1, 8'hFF, 0, 0, 32'h0,        32'h0,        0);
        add(1, 8'hFF, 0, 0, 32'h0,        32'h0,        0);
        add(0, 8'hFF, 0, 0, 32'h0,        32'h0,        0);
        add(0, 8'hFF, 0, 0, 32'h0,        32'h0,        0);
        add(0, 8'hFF, 0, 0, 32'h0,        32'h0,        0);
        add(0, 8'hFF, 0, 0, 32'h0,        32'h000000FF, 0);
        add(0, 8'hFF, 3, 0, 32'h0,        32'h0,        0);
        add(0, 8'h00, 0, 0, 32'h0,        32'h000000FF, 0);
        add(0, 8'h00, 0, 0, 32'h0,        32'h000000FF, 0);
        add(0, 8'h00, 0, 0, 32'h0,        32'h000000FF, 0);
        add(0, 8'h00, 0, 0, 32'h0,        32'h0,        0);
        add(0, 8'h00, 1, 1, 32'h1,        32'h0,        0);
        add(0, 8'h00, 1, 0, 32'h0,        32'h1,        0);
        add(0, 8'h05, 3, 0, 32'h0,        32'h0,        0);
        add(0, 8'h05, 3, 0, 32'h0,        32'h0,        0);
        add(0, 8'h05, 3, 0, 32'h0,        32'h0,        0);
        add(0, 8'h05, 3, 0, 32'h0,        32'h0,        1);
        add(0, 8'h05, 0, 0, 32'h0,        32'h5,        1);
        add(0, 8'h05, 3, 0, 32'h0,        32'h5,        1);
        add(0, 8'h05, 3, 1, 32'h1,        32'h5,        0);
        add(0, 8'h05, 3, 0, 32'h0,        32'h4,        0);
        add(0, 8'h01, 3, 0, 32'h0,        32'h4,        0);
        add(0, 8'h01, 3, 0, 32'h0,        32'h4,        0);
        add(0, 8'h05, 3, 0, 32'h0,        32'h4,        0);
        add(0, 8'h05, 3, 0, 32'h0,        32'h4,        0);
        add(0, 8'h05, 3, 0, 32'h0,        32'h4,        0);
        add(0, 8'h05, 3, 1, 32'h4,        32'h4,        0);
        add(0, 8'h05, 3, 0, 32'h0,        32'h4,        0);
        add(0, 8'h05, 1, 1, 32'h4,        32'h1,        1);
        add(0, 8'h05, 1, 0, 32'h0,        32'h4,        1);
        add(0, 8'h05, 2, 1, 32'hFFFFFFFF, 32'h0,        1);
        add(0, 8'h05, 0, 1, 32'h0,        32'h5,        1);
        add(0, 8'h05, 0, 0, 32'h0,        32'h5,        1);
        add(0, 8'h05, 1, 1, 32'h0,        32'h4,        0);
        add(0, 8'h05, 3, 0, 32'h0,        32'h4,        0);

        for (int i = 0; i < vt.size(); i++) begin
            reset = vt[i].rst;
            in_a  = vt[i].din;
            expect_at(0, vt[i].erd, vt[i].eirq, $sformatf("vec%0d", i));
            bus(vt[i].a, vt[i].w, vt[i].wd);
        end

        // dut_b, DEBOUNCE_CYCLES=4: a 3-cycle pulse must be rejected.
        bus(1, 1, 32'h1);
        in_b = 8'h01;
        for (int i = 0; i < 3; i++) begin
            expect_at(1, 32'h0, 1'b0, "b_pulse");
            bus(0, 0, 32'h0);
        end
        in_b = 8'h00;
        for (int i = 0; i < 8; i++) begin
            expect_at(1, 32'h0, 1'b0, "b_pulse_data");
            bus(0, 0, 32'h0);
        end
        expect_at(1, 32'h0, 1'b0, "b_pulse_cap");
        bus(3, 0, 32'h0);

        // dut_b: held 4 samples -> stable flips at k+5, capture/irq at k+6.
        in_b = 8'h01;
        for (int i = 0; i < 6; i++) begin
            expect_at(1, 32'h0, 1'b0, $sformatf("b_hold%0d", i));
            bus(0, 0, 32'h0);
        end
        expect_at(1, 32'h1, 1'b1, "b_flip_k6");
        bus(0, 0, 32'h0);
        expect_at(1, 32'h1, 1'b1, "b_cap_k7");
        bus(3, 0, 32'h0);
        expect_at(1, 32'h1, 1'b0, "b_clr");
        bus(3, 1, 32'h1);
        expect_at(1, 32'h0, 1'b0, "b_cap_cleared");
        bus(3, 0, 32'h0);
        bus(1, 1, 32'h0);

        // dut_c, 32 bits, any-edge: bit 31 rise then fall both capture.
        in_c = 32'h8000_0000;
        for (int i = 0; i < 3; i++) begin
            expect_at(2, 32'h0, 1'b0, "c_rise_wait");
            bus(3, 0, 32'h0);
        end
        expect_at(2, 32'h8000_0000, 1'b0, "c_data_hi");
        bus(0, 0, 32'h0);
        expect_at(2, 32'h8000_0000, 1'b0, "c_cap_rise");
        bus(3, 0, 32'h0);
        expect_at(2, 32'h8000_0000, 1'b0, "c_clr");
        bus(3, 1, 32'h8000_0000);
        expect_at(2, 32'h0, 1'b0, "c_cap_cleared");
        bus(3, 0, 32'h0);
        in_c = 32'h0;
        for (int i = 0; i < 3; i++) begin
            expect_at(2, 32'h0, 1'b0, "c_rsvd");
            bus(2, 0, 32'h0);
        end
        expect_at(2, 32'h0, 1'b0, "c_fall_wait");
        bus(3, 0, 32'h0);
        expect_at(2, 32'h8000_0000, 1'b0, "c_cap_fall");
        bus(3, 0, 32'h0);

        // dut_a capture all bits with mask FF, then reset mid-operation.
        bus(1, 1, 32'hFF);
        in_a = 8'h00;
        for (int i = 0; i < 4; i++) bus(0, 0, 32'h0);
        in_a = 8'hFF;
        for (int i = 0; i < 4; i++) bus(0, 0, 32'h0);
        expect_at(0, 32'hFF, 1'b1, "a_cap_ff");
        bus(3, 0, 32'h0);
        in_b = 8'h00;
        for (int i = 0; i < 2; i++) bus(3, 0, 32'h0);
        reset = 1'b1;
        expect_at(0, 32'h0, 1'b0, "a_reset");
        expect_at(1, 32'h0, 1'b0, "b_reset");
        bus(3, 0, 32'h0);
        reset = 1'b0;
        warm_exp[0] = 32'h0;
        warm_exp[1] = 32'h0;
        warm_exp[2] = 32'h0;
        warm_exp[3] = 32'hFF;
        for (int i = 0; i < 4; i++) begin
            expect_at(0, warm_exp[i], 1'b0, $sformatf("a_rewarm%0d", i));
            bus(0, 0, 32'h0);
        end
        expect_at(0, 32'h0, 1'b0, "a_rewarm_cap");
        expect_at(1, 32'h0, 1'b0, "b_rewarm_cap");
        bus(3, 0, 32'h0);
        in_b = 8'h01;
        for (int i = 0; i < 2; i++) bus(0, 0, 32'h0);
        in_b = 8'h00;
        j = 0;
        while (j < 8) begin
            expect_at(1, 32'h0, 1'b0, "b_bounce_discard");
            bus(0, 0, 32'h0);
            j++;
        end

        chipselect = 1'b0;
        write      = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        if (sb.size() != 0) begin
            errors += sb.size();
            $display("FAIL scoreboard_drain: %0d expectations left, required 0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
